loop_stack: RTL and testbench
=============================

LOOP_STACK -- requirements
Module: loop_stack

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of each stacked entry (loop-start instruction address).
REQ-002 Parameter ADDR_WIDTH, default 8, RAM index width; the stack capacity is DEPTH = 2**ADDR_WIDTH entries.
REQ-003 Port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port push, input, 1, push request, qualified by ready.
REQ-006 Port pop, input, 1, pop request, qualified by ready.
REQ-007 Port push_data, input, DATA_WIDTH, entry to push.
REQ-008 Port ready, output, 1, block accepts push/pop this cycle.
REQ-009 Port top_data, output, DATA_WIDTH, current top entry, valid when ready=1 and empty=0.
REQ-010 Port count, output, ADDR_WIDTH+1, number of entries held.
REQ-011 Port empty, output, 1, count==0.
REQ-012 Port full, output, 1, count==DEPTH.
REQ-013 Port err, output, 1, sticky overflow/underflow flag.

Function
REQ-014 Storage: the top entry is held in register top_q, driving top_data; entries 0..count-2 are held in a DEPTH-entry synchronous RAM, with entry 0 at the bottom.
REQ-015 States: IDLE (ready=1) and REFILL (ready=0); REFILL always returns to IDLE after exactly one cycle.
REQ-016 Push alone, IDLE, not full: if count>0, RAM[count-1] <= top_q; top_q <= push_data; count+1; top_data shows new value next cycle.
REQ-017 Pop alone, IDLE, count>=2: RAM read issued at address count-2; count-1; enter REFILL.
REQ-018 In REFILL, top_q <= RAM read data; ready returns to 1 on the following cycle (pop-to-ready latency 2 cycles).
REQ-019 Pop alone, IDLE, count==1: count becomes 0; no RAM access; remain IDLE; top_q retains its stale value.
REQ-020 Push and pop together, IDLE, count>=1: top_q <= push_data; count unchanged; no RAM access; remain IDLE; allowed when full.
REQ-021 Push and pop together, IDLE, empty: behaves as push alone; the pop counts as an underflow.
REQ-022 Push when full (without pop): ignored; state unchanged; counts as an overflow.
REQ-023 Pop when empty (without push): ignored; counts as an underflow.
REQ-024 push/pop asserted while ready=0: ignored, no error, no state change.
REQ-025 A RAM write and a RAM read never occur in the same cycle, so no read/write collision logic is required.
REQ-026 empty, full and count are registered-consistent; they update in the same cycle as count.

Reset
REQ-027 While rst_n=0: count=0, empty=1, full=0, ready=1, state IDLE, top_data=0, err=0.
REQ-028 Reset asserted during REFILL aborts the refill; the first cycle after release is IDLE with an empty stack.
REQ-029 RAM contents are not reset; no RAM location is read before it is written.

Configuration
REQ-030 Macro LOOP_STACK_ERR_EN defined: err sets on any overflow (REQ-022) or underflow (REQ-021, REQ-023) and holds until reset.
REQ-031 Macro LOOP_STACK_ERR_EN undefined: err is tied to 0 and no error logic is synthesised; REQ-021 to REQ-023 guarding is unchanged.

Verification
REQ-032 Push 0x0010, 0x0020, 0x0030 -> count=3, top_data=0x0030; pop -> ready=0 one cycle, then top_data=0x0020, count=2.
REQ-033 ADDR_WIDTH=2: push 4 entries -> full=1; 5th push of 0xBEEF -> ignored, count=4, err=1 (macro on) / err=0 (macro off).
REQ-034 Empty stack, pop -> count=0, empty=1, err=1 (macro on); then push+pop of 0x0042 together -> count=1, top_data=0x0042.
REQ-035 count=2, top=0x0005, push+pop of 0x0007 together -> count=2, top_data=0x0007, ready stays 1; pop -> top_data is the entry below.
REQ-036 Pop from count=3, rst_n=0 during REFILL -> after release count=0, empty=1, ready=1, top_data=0, err=0.

Source files
------------

// File: rtl/loop_stack.sv
// loop_stack: hardware stack of loop-start addresses.
// The top entry lives in a register (top_q) so it is visible with no RAM
// latency. Deeper entries live in a synchronous single-port RAM.
// A pop that exposes a RAM entry needs one REFILL cycle, during which
// ready is low.
//
// Handshake: push and pop are sampled only on a rising clk edge where
// ready=1. A request made while ready=0 is dropped: no state change and no
// error. When both push and pop are set on a non-empty stack, the top entry
// is replaced in place.
//
// Optional feature: define LOOP_STACK_ERR_EN to build a sticky err flag.
// The flag sets on overflow (push when full) or underflow (pop when empty)
// and holds until reset. Without the macro, err is tied to 0.
module loop_stack #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic                  ready,
   output logic [DATA_WIDTH-1:0] top_data,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  empty,
   output logic                  full,
   output logic                  err
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] FULL_CNT = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0] TWO      = ONE + ONE;

   typedef enum logic {
      IDLE   = 1'b0,
      REFILL = 1'b1
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH:0]     count_q, count_d;
   logic [DATA_WIDTH-1:0]   top_q, top_d;

   // Deeper entries; index 0 is the bottom of the stack.
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
   logic [DATA_WIDTH-1:0]   rd_data_q;
   logic                    ram_we, ram_re;
   logic [ADDR_WIDTH-1:0]   ram_waddr, ram_raddr;

   logic                    is_empty, is_full, idle;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == FULL_CNT);
   assign idle     = (state_q == IDLE);

   // On a push, the old top goes to slot count-1. On a pop, the new top is
   // read from slot count-2. Neither wraps when it is used.
   assign ram_waddr = ADDR_WIDTH'(count_q - ONE);
   assign ram_raddr = ADDR_WIDTH'(count_q - TWO);

   // Next-state, counter and RAM control; IDLE is the only accepting state.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      top_d   = top_q;
      ram_we  = 1'b0;
      ram_re  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (push && pop) begin
               // Replace the top in place. On an empty stack this acts as a plain push.
               top_d = push_data;
               if (is_empty) begin
                  count_d = ONE;
               end
            end else if (push) begin
               if (!is_full) begin
                  ram_we  = !is_empty;
                  top_d   = push_data;
                  count_d = count_q + ONE;
               end
            end else if (pop) begin
               if (count_q == ONE) begin
                  // The stale top value is kept on purpose; only count drops.
                  count_d = '0;
               end else if (!is_empty) begin
                  ram_re  = 1'b1;
                  count_d = count_q - ONE;
                  state_d = REFILL;
               end
            end
         end
         REFILL: begin
            top_d   = rd_data_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and top-of-stack registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         top_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         top_q   <= top_d;
      end
   end

   // Synchronous RAM. Writes and reads are never issued in the same cycle.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem_q[ram_waddr] <= top_q;
      end
      if (ram_re) begin
         rd_data_q <= mem_q[ram_raddr];
      end
   end

`ifdef LOOP_STACK_ERR_EN
   logic err_q;
   logic overflow, underflow;

   assign overflow  = idle && push && !pop && is_full;
   assign underflow = idle && pop && is_empty;

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (overflow || underflow) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign ready    = idle;
   assign top_data = top_q;
   assign count    = count_q;
   assign empty    = is_empty;
   assign full     = is_full;

endmodule

// File: tb/tb_loop_stack.sv
// tb_loop_stack: directed test of loop_stack with ADDR_WIDTH=2 (depth 4).
// The expected value of err depends on LOOP_STACK_ERR_EN.
module tb_loop_stack;

   localparam int DW = 16;
   localparam int AW = 2;
`ifdef LOOP_STACK_ERR_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic          push;
   logic          pop;
   logic [DW-1:0] push_data;
   logic          ready;
   logic [DW-1:0] top_data;
   logic [AW:0]   count;
   logic          empty;
   logic          full;
   logic          err;

   int errors = 0;
   int checks = 0;

   loop_stack #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .push_data (push_data),
      .ready     (ready),
      .top_data  (top_data),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .err       (err)
   );

   // Clock and safety timeout.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, need finished");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Applies one request for one clock edge. Returns at the following negedge.
   task automatic step(input logic p, input logic q, input logic [DW-1:0] d);
      @(negedge clk);
      push = p; pop = q; push_data = d;
      @(negedge clk);
      push = 1'b0; pop = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      for (int i = 0; i < 4; i++) begin
         if (ready) break;
         @(negedge clk);
      end
      check_eq(tag, 32'(ready), 32'd1);
   endtask

   // Pop that goes through REFILL. Checks that ready drops, then waits for it.
   task automatic pop_refill(input string tag);
      step(1'b0, 1'b1, '0);
      check_eq({tag, "_busy"}, 32'(ready), 32'd0);
      wait_ready({tag, "_ready"});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_state(input string tag, input int exp_cnt, input logic [DW-1:0] exp_top);
      check_eq({tag, "_count"}, 32'(count), 32'(exp_cnt));
      check_eq({tag, "_top"}, 32'(top_data), 32'(exp_top));
      check_eq({tag, "_empty"}, 32'(empty), 32'(exp_cnt == 0));
      check_eq({tag, "_full"}, 32'(full), 32'(exp_cnt == 4));
   endtask

   initial begin
      push = 1'b0; pop = 1'b0; push_data = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);

      // Values while reset is held.
      check_state("rst", 0, 16'h0000);
      check_eq("rst_ready", 32'(ready), 32'd1);
      check_eq("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;

      // Basic push, then pop with a refill.
      step(1'b1, 1'b0, 16'h0010);
      step(1'b1, 1'b0, 16'h0020);
      step(1'b1, 1'b0, 16'h0030);
      check_state("push3", 3, 16'h0030);
      pop_refill("pop1");
      check_state("pop1", 2, 16'h0020);
      pop_refill("pop2");
      check_state("pop2", 1, 16'h0010);
      step(1'b0, 1'b1, '0);
      check_eq("pop_last_ready", 32'(ready), 32'd1);
      check_eq("pop_last_count", 32'(count), 32'd0);
      check_eq("pop_last_empty", 32'(empty), 32'd1);
      check_eq("pop_last_err", 32'(err), 32'd0);

      // Fill to capacity, then overflow.
      for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 16'(i));
      check_state("fill", 4, 16'h0004);
      step(1'b1, 1'b0, 16'hBEEF);
      check_state("ovf", 4, 16'h0004);
      check_eq("ovf_err", 32'(err), 32'(ERR_EN));
      pop_refill("drain3");
      check_state("drain3", 3, 16'h0003);
      pop_refill("drain2");
      check_state("drain2", 2, 16'h0002);
      pop_refill("drain1");
      check_state("drain1", 1, 16'h0001);
      step(1'b0, 1'b1, '0);
      check_state("drain0", 0, 16'h0001);
      do_reset();
      check_eq("rst2_err", 32'(err), 32'd0);

      // Underflow, then push and pop together on an empty stack.
      step(1'b0, 1'b1, '0);
      check_state("udf", 0, 16'h0000);
      check_eq("udf_err", 32'(err), 32'(ERR_EN));
      check_eq("udf_ready", 32'(ready), 32'd1);
      step(1'b1, 1'b1, 16'h0042);
      check_state("pp_empty", 1, 16'h0042);

      // Replace the top in place, then pop back down to the entry below.
      step(1'b1, 1'b0, 16'h0005);
      check_state("push5", 2, 16'h0005);
      step(1'b1, 1'b1, 16'h0007);
      check_state("replace", 2, 16'h0007);
      check_eq("replace_ready", 32'(ready), 32'd1);
      pop_refill("pop_below");
      check_state("pop_below", 1, 16'h0042);

      // Push and pop together while full is still allowed.
      step(1'b1, 1'b0, 16'h000A);
      step(1'b1, 1'b0, 16'h000B);
      step(1'b1, 1'b0, 16'h000C);
      check_state("refill_full", 4, 16'h000C);
      step(1'b1, 1'b1, 16'h000D);
      check_state("pp_full", 4, 16'h000D);
      pop_refill("pop_pp_full");
      check_state("pop_pp_full", 3, 16'h000B);

      // A request made during REFILL is ignored.
      @(negedge clk);
      pop = 1'b1;
      @(negedge clk);
      pop = 1'b0; push = 1'b1; push_data = 16'h0099;
      check_eq("busy_ready", 32'(ready), 32'd0);
      @(negedge clk);
      push = 1'b0;
      check_eq("ign_ready", 32'(ready), 32'd1);
      check_state("ign", 2, 16'h000A);
      check_eq("sticky_err", 32'(err), 32'(ERR_EN));

      // Reset during REFILL.
      step(1'b1, 1'b0, 16'h0077);
      check_state("pre_rst", 3, 16'h0077);
      @(negedge clk);
      pop = 1'b1;
      @(negedge clk);
      pop = 1'b0;
      check_eq("rr_busy", 32'(ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check_eq("rr_async_count", 32'(count), 32'd0);
      check_eq("rr_async_ready", 32'(ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_state("rr_after", 0, 16'h0000);
      check_eq("rr_after_ready", 32'(ready), 32'd1);
      check_eq("rr_after_err", 32'(err), 32'd0);
      step(1'b1, 1'b0, 16'h0011);
      check_state("rr_push", 1, 16'h0011);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
